// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: divider FSM states and a
// width helper for sizing counters.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bits needed to hold values 0..v-1 (returns 0 for v<=1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/cla_adder.sv
// W-bit carry-lookahead adder built from 4-bit groups; group
// generate/propagate terms form the carry chain between groups.
module cla_adder #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned G  = 4;
    localparam int unsigned NG = (W + G - 1) / G;

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] c;

    assign g = x & y;
    assign p = x ^ y;

    always_comb begin
        logic carry;
        logic gg;
        logic gp;
        logic acc;
        c     = '0;
        carry = cin;
        for (int unsigned b = 0; b < NG; b++) begin
            gg  = 1'b0;
            gp  = 1'b1;
            acc = carry;
            for (int unsigned k = 0; k < G; k++) begin
                if (b * G + k < W) begin
                    c[b*G+k] = acc;
                    acc      = g[b*G+k] | (p[b*G+k] & acc);
                    gg       = g[b*G+k] | (p[b*G+k] & gg);
                    gp       = gp & p[b*G+k];
                end
            end
            carry = gg | (gp & carry);
        end
        cout = carry;
    end

    assign sum = p ^ c;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle,
// trial subtraction on a shared carry-lookahead adder, valid/ready on both sides.
module seq_divider
    import arith_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = clog2(N + 1);

    state_t        state;
    state_t        next;
    logic [N-1:0]  d_reg;
    logic [N-1:0]  qsr;
    logic [N:0]    r;
    logic [CW-1:0] cnt;
    logic          dbz;

    logic [N:0]    r_shift;
    logic [N:0]    trial;
    logic          no_borrow;
    logic          unused_r_msb;

    assign r_shift = {r[N-1:0], qsr[N-1]};

    // x - d computed as x + ~{0,d} + 1; carry-out high means no borrow.
    cla_adder #(.W(N + 1)) u_sub (
        .x    (r_shift),
        .y    (~{1'b0, d_reg}),
        .cin  (1'b1),
        .sum  (trial),
        .cout (no_borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next = (divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == CW'(1)) begin
                    next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg <= '0;
            qsr   <= '0;
            r     <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_reg <= divisor;
                        cnt   <= CW'(N);
                        if (divisor == '0) begin
                            qsr <= '1;
                            r   <= {1'b0, dividend};
                            dbz <= 1'b1;
                        end else begin
                            qsr <= dividend;
                            r   <= '0;
                            dbz <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    qsr <= {qsr[N-2:0], no_borrow};
                    r   <= no_borrow ? trial : r_shift;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign quotient     = qsr;
    assign remainder    = r[N-1:0];
    assign div_by_zero  = dbz;
    // Remainder is always below the divisor, so the top bit stays clear.
    assign unused_r_msb = r[N];

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases, backpressure,
// mid-operation reset and randomized back-to-back divisions.
module tb_seq_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) on negedges for out_valid; lat counts cycles after the accept edge.
    task automatic wait_valid(input bit drop, output int lat);
        lat = 0;
        for (int k = 0; k < 4 * N; k++) begin
            @(negedge clk);
            if (drop) in_valid = 1'b0;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) check("timeout_out_valid", 0, 1);
    endtask

    // Directed division from IDLE with out_ready high; compares against plain arithmetic.
    task automatic run_op(input int a, input int b);
        int lat;
        int eq, er, ez, el;
        if (b == 0) begin
            eq = (1 << N) - 1; er = a; ez = 1; el = 1;
        end else begin
            eq = a / b; er = a % b; ez = 0; el = N + 1;
        end
        check($sformatf("ready_%0d_%0d", a, b), in_ready, 1);
        in_valid = 1'b1;
        dividend = N'(a);
        divisor  = N'(b);
        wait_valid(1'b1, lat);
        check($sformatf("lat_%0d_%0d", a, b), lat, el);
        check($sformatf("quot_%0d_%0d", a, b), quotient, eq);
        check($sformatf("rem_%0d_%0d", a, b), remainder, er);
        check($sformatf("dbz_%0d_%0d", a, b), div_by_zero, ez);
        check($sformatf("busy_ready_%0d_%0d", a, b), in_ready, 0);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int a, b;
        int acc_prev, acc_now;
        bit seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(100, 7);
        run_op(255, 1);
        run_op(5, 9);
        run_op(255, 255);
        run_op(0, 3);
        run_op(13, 0);
        run_op(200, 13);

        // Backpressure: result must hold while out_ready is low; new operands ignored.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = 8'd77;
        divisor   = 8'd6;
        wait_valid(1'b1, lat);
        check("bp_lat", lat, N + 1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            dividend = 8'd3;
            divisor  = 8'd1;
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_quotient", quotient, 77 / 6);
            check("bp_remainder", remainder, 77 % 6);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1);
        check("bp_release_valid", out_valid, 0);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_no_accept", in_ready, 1);

        // Reset in the fourth BUSY cycle discards the in-flight result.
        in_valid = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_quotient", quotient, 0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < N + 2; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_discarded", seen, 0);
        run_op(200, 13);

        // Randomized back-to-back traffic with in_valid held high.
        acc_prev  = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 4 * N && !in_ready; k++) @(negedge clk);
            check("rand_ready", in_ready, 1);
            a = int'($urandom_range(0, (1 << N) - 1));
            b = int'($urandom_range(1, (1 << N) - 1));
            dividend = N'(a);
            divisor  = N'(b);
            acc_now  = cyc + 1;
            if (i > 0) check("rand_spacing", acc_now - acc_prev, N + 2);
            acc_prev = acc_now;
            wait_valid(1'b0, lat);
            check("rand_identity", int'(quotient) * b + int'(remainder), a);
            check("rand_rem_lt_div", int'(remainder) < b, 1);
            check("rand_quotient", quotient, a / b);
        end
        in_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
